// File: rtl/video_fetch_shifter.sv
// video_fetch_shifter: per character cell, fetches one 24-bit three-plane word
// from VRAM over a req/ack port and serialises 8 pixels per plane. Colour and
// de/hs/vs come out exactly one character period after the CRTC presented them.
// Optional feature macro: VFS_CURSOR_EN (cursor delayed like de and inverts
// the displayed pixels while active).
module video_fetch_shifter #(
  parameter int AW     = 16,
  parameter int UCNT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              crtc_ce,
  input  logic              pix_ce,
  input  logic              de,
  input  logic              hs,
  input  logic              vs,
  input  logic              cursor,
  input  logic [13:0]       ma,
  input  logic [4:0]        ra,
  output logic              vram_req,
  output logic [AW-1:0]     vram_addr,
  input  logic              vram_ack,
  input  logic [23:0]       vram_d,
  output logic              r,
  output logic              g,
  output logic              b,
  output logic              de_o,
  output logic              hs_o,
  output logic              vs_o,
  output logic [UCNT_W-1:0] underrun
);

  typedef enum logic [1:0] {IDLE, REQ, LATE} state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [23:0]         hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic                bypass;
  logic [AW-1:0]       cell_addr;
  logic [23:0]         load_data;
  logic                load_valid;

  logic [7:0]          sr_r_q, sr_g_q, sr_b_q;
  logic                de_h_q, hs_h_q, vs_h_q;
  logic                de_o_q, hs_o_q, vs_o_q;
  logic [UCNT_W-1:0]   underrun_q;
  logic                inv;

  // Upper ma bits and ra[4:3] are deliberately ignored; cursor is only
  // consumed when the cursor feature is built in.
  logic                unused_inputs;
  assign unused_inputs = ^{cursor, ma, ra};

  assign cell_addr = {ma[AW-4:0], ra[2:0]};

  // Fetch FSM next state: request per displayed cell, detect late acks.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    bypass       = 1'b0;
    if (crtc_ce) hold_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (crtc_ce && de) begin
          addr_d  = cell_addr;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (vram_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (crtc_ce) begin
            // Ack on the load edge: data goes straight to the shifters and
            // the newly presented cell is handled as if from IDLE.
            bypass = 1'b1;
            if (de) begin
              addr_d  = cell_addr;
              req_d   = 1'b1;
              state_d = REQ;
            end
          end else begin
            hold_d       = vram_d;
            hold_valid_d = 1'b1;
          end
        end else if (crtc_ce) begin
          state_d = LATE;
        end
      end
      LATE: begin
        if (vram_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (crtc_ce && de) begin
            addr_d  = cell_addr;
            req_d   = 1'b1;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch FSM and hold register state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign load_valid = bypass | hold_valid_q;
  assign load_data  = bypass ? vram_d : (hold_valid_q ? hold_q : 24'h000000);

  // Character-rate load / pixel-rate shift, timing delay line, underrun count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_r_q     <= '0;
      sr_g_q     <= '0;
      sr_b_q     <= '0;
      de_h_q     <= 1'b0;
      hs_h_q     <= 1'b0;
      vs_h_q     <= 1'b0;
      de_o_q     <= 1'b0;
      hs_o_q     <= 1'b0;
      vs_o_q     <= 1'b0;
      underrun_q <= '0;
    end else if (crtc_ce) begin
      sr_r_q <= load_data[23:16];
      sr_g_q <= load_data[15:8];
      sr_b_q <= load_data[7:0];
      de_h_q <= de;
      hs_h_q <= hs;
      vs_h_q <= vs;
      de_o_q <= de_h_q;
      hs_o_q <= hs_h_q;
      vs_o_q <= vs_h_q;
      if (de_h_q && !load_valid && (underrun_q != {UCNT_W{1'b1}}))
        underrun_q <= underrun_q + UCNT_W'(1);
    end else if (pix_ce) begin
      sr_r_q <= {sr_r_q[6:0], 1'b0};
      sr_g_q <= {sr_g_q[6:0], 1'b0};
      sr_b_q <= {sr_b_q[6:0], 1'b0};
    end
  end

`ifdef VFS_CURSOR_EN
  logic cursor_h_q, cursor_o_q;

  // Cursor follows the same two-stage character delay as de.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cursor_h_q <= 1'b0;
      cursor_o_q <= 1'b0;
    end else if (crtc_ce) begin
      cursor_h_q <= cursor;
      cursor_o_q <= cursor_h_q;
    end
  end

  assign inv = cursor_o_q & de_o_q;
`else
  assign inv = 1'b0;
`endif

  assign r         = (sr_r_q[7] ^ inv) & de_o_q;
  assign g         = (sr_g_q[7] ^ inv) & de_o_q;
  assign b         = (sr_b_q[7] ^ inv) & de_o_q;
  assign de_o      = de_o_q;
  assign hs_o      = hs_o_q;
  assign vs_o      = vs_o_q;
  assign vram_req  = req_q;
  assign vram_addr = addr_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_video_fetch_shifter.sv
// Directed bench for video_fetch_shifter: one character period is 8 clocks,
// crtc_ce on the first clock and pix_ce on every clock (the coincident pulse
// is absorbed by the load), so each period shows exactly 8 pixels.
// Honours VFS_CURSOR_EN for the cursor expectation.
module tb_video_fetch_shifter;

  logic        clock = 1'b0;
  logic        reset, crtc_ce, pix_ce, de, hs, vs, cursor;
  logic [13:0] ma;
  logic [4:0]  ra;
  logic        vram_req, vram_ack;
  logic [15:0] vram_addr;
  logic [23:0] vram_d;
  logic        r, g, b, de_o, hs_o, vs_o;
  logic [7:0]  underrun;

  int vectors = 0;
  int miscompares = 0;

  // Per-period observations.
  logic [7:0]  pr, pg, pb;
  logic [15:0] addr0;
  logic        req0, req_any, req_end, deo0, hso0, vso0;
  logic [7:0]  und0;
  logic [23:0] cursor_exp;

  video_fetch_shifter #(.AW(16), .UCNT_W(8)) dut (
    .clock(clock), .reset(reset), .crtc_ce(crtc_ce), .pix_ce(pix_ce),
    .de(de), .hs(hs), .vs(vs), .cursor(cursor), .ma(ma), .ra(ra),
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack), .vram_d(vram_d),
    .r(r), .g(g), .b(b), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .underrun(underrun)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One character period. ack0/d0: ack on the crtc_ce clock; ackc/d: ack on
  // clock ackc (1..7) of the period, or none when ackc is 0.
  task automatic period(input logic c_de, input logic c_hs, input logic c_vs,
                        input logic c_cur, input logic [13:0] c_ma, input logic [4:0] c_ra,
                        input logic ack0, input logic [23:0] d0,
                        input int ackc, input logic [23:0] d);
    crtc_ce = 1'b1; de = c_de; hs = c_hs; vs = c_vs; cursor = c_cur;
    ma = c_ma; ra = c_ra; vram_ack = ack0; vram_d = d0;
    tick();
    crtc_ce = 1'b0; vram_ack = 1'b0;
    addr0 = vram_addr; req0 = vram_req; deo0 = de_o; hso0 = hs_o; vso0 = vs_o;
    und0 = underrun; req_any = vram_req;
    pr = {7'b0, r}; pg = {7'b0, g}; pb = {7'b0, b};
    for (int i = 1; i < 8; i++) begin
      vram_ack = (i == ackc);
      vram_d = d;
      tick();
      pr = {pr[6:0], r}; pg = {pg[6:0], g}; pb = {pb[6:0], b};
      req_any = req_any | vram_req;
    end
    vram_ack = 1'b0;
    req_end = vram_req;
  endtask

  initial begin
    reset = 1'b1; crtc_ce = 1'b0; pix_ce = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0;
    cursor = 1'b0; ma = '0; ra = '0; vram_ack = 1'b0; vram_d = '0;
    tick(); tick();
    chk("rst_req", vram_req, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_sync", {de_o, hs_o, vs_o}, 0);
    chk("rst_underrun", underrun, 0);
    reset = 1'b0;
    tick();

    // Basic fetch: ma=0x12, ra=3 -> addr 0x93
    period(1, 1, 0, 0, 14'h0012, 5'd3, 0, 0, 2, 24'hF00FAA);
    chk("t1_req", req0, 1);
    chk("t1_addr", addr0, 16'h0093);
    chk("t1_req_done", req_end, 0);
    period(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_R", pr, 8'hF0);
    chk("t1_G", pg, 8'h0F);
    chk("t1_B", pb, 8'hAA);
    chk("t1_de_o", deo0, 1);
    chk("t1_hs_o", hso0, 1);
    chk("t1_underrun", und0, 0);
    chk("t2_noreq_a", req_any, 0);

    // Blank cells: no requests, black, de_o low one char later
    period(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_rgb", {pr, pg, pb}, 0);
    chk("t2_de_o", deo0, 0);
    chk("t2_vs_o", {hso0, vso0}, 2'b01);
    chk("t2_noreq_b", req_any, 0);
    period(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    period(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_rgb_end", {pr, pg, pb}, 0);
    chk("t2_noreq_c", req_any, 0);
    chk("t2_underrun", und0, 0);

    // Late ack: ma=0x20, ra=1 -> addr 0x101 stays pending into the next cell
    period(1, 0, 0, 0, 14'h0020, 5'd1, 0, 0, 0, 0);
    chk("t3_addr", addr0, 16'h0101);
    chk("t3_req_pending", req_end, 1);
    period(1, 0, 0, 0, 14'h0021, 5'd0, 0, 0, 3, 24'hFFFFFF);
    chk("t3_underrun1", und0, 1);
    chk("t3_de_o", deo0, 1);
    chk("t3_blank", {pr, pg, pb}, 0);
    chk("t3_req_held", req0, 1);
    chk("t3_addr_held", addr0, 16'h0101);
    chk("t3_req_released", req_end, 0);
    // The cell presented during LATE was never fetched either.
    period(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_underrun2", und0, 2);
    chk("t3_late_hidden", {pr, pg, pb}, 0);
    chk("t3_noreq", req_any, 0);

    // Ack coincident with crtc_ce: bypass load, new request next clock
    period(1, 0, 0, 0, 14'h0005, 5'd7, 0, 0, 0, 0);
    chk("t4_addr", addr0, 16'h002F);
    chk("t4_req_pending", req_end, 1);
    period(1, 0, 0, 0, 14'h0006, 5'd2, 1, 24'hFFFFFF, 4, 24'h123456);
    chk("t4_white", {pr, pg, pb}, 24'hFFFFFF);
    chk("t4_underrun", und0, 2);
    chk("t4_next_req", req0, 1);
    chk("t4_next_addr", addr0, 16'h0032);
    period(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_after_bypass", {pr, pg, pb}, 24'h123456);
    chk("t4_underrun_b", und0, 2);

    // Underrun saturation: displayed cells with no ack at all
    for (int k = 0; k < 258; k++) period(1, 0, 0, 0, 14'h0007, 5'd0, 0, 0, 0, 0);
    chk("sat_underrun", underrun, 8'hFF);
    chk("sat_req_stuck", vram_req, 1);

    // Asynchronous reset mid-transaction
    #2 reset = 1'b1;
    #1;
    chk("t5_req_async", vram_req, 0);
    chk("t5_addr", vram_addr, 0);
    chk("t5_underrun", underrun, 0);
    chk("t5_outs", {r, g, b, de_o, hs_o, vs_o}, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    period(1, 0, 0, 0, 14'h0001, 5'd5, 0, 0, 2, 24'h81C3E7);
    chk("t5_req", req0, 1);
    chk("t5_addr2", addr0, 16'h000D);
    period(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_pixels", {pr, pg, pb}, 24'h81C3E7);
    chk("t5_underrun2", und0, 0);
    chk("t5_de_o", deo0, 1);

    // Cursor over zero data
`ifdef VFS_CURSOR_EN
    cursor_exp = 24'hFFFFFF;
`else
    cursor_exp = 24'h000000;
`endif
    period(1, 0, 0, 1, 14'h0000, 5'd0, 0, 0, 2, 24'h000000);
    period(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_cursor", {pr, pg, pb}, cursor_exp);
    chk("t6_de_o", deo0, 1);
    period(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_blank_after", {pr, pg, pb}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
